// File: rtl/sha256_apb_blk_if.sv
// APB3 bus bundle between the peripheral bus master and the SHA-256 front-end.
interface sha256_apb_blk_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/sha256_apb_blk.sv
// APB slave front-end for an external SHA-256 compression core: buffers one
// message block, launches the core (fresh IV or chained) and captures the digest.
module sha256_apb_blk #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int MSG_WORDS      = 16,
    parameter int DIGEST_WORDS   = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    sha256_apb_blk_if.slave           apb,
    output logic                      core_start_o,
    output logic                      core_init_o,
    output logic [32*MSG_WORDS-1:0]   core_block_o,
    input  logic [32*DIGEST_WORDS-1:0] core_digest_i,
    input  logic                      core_done_i,
    output logic                      int_o
);
    typedef enum logic {IDLE, HASH} state_t;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_CMD    = 6'h01;
    localparam logic [5:0] A_STATUS = 6'h02;
    localparam logic [5:0] A_MSG    = 6'h04;
    localparam int         A_DIG    = 8;
    localparam logic [4:0] FULL_CNT = 5'(MSG_WORDS);

    state_t      state_q, state_d;
    logic [31:0] buf_q [MSG_WORDS];
    logic [31:0] buf_d [MSG_WORDS];
    logic [31:0] dig_q [DIGEST_WORDS];
    logic [31:0] dig_d [DIGEST_WORDS];
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        int_flag_q, int_flag_d;
    logic        err_q, err_d;
    logic        auto_pend_q, auto_pend_d;
    logic        start_q, start_d;
    logic        init_q, init_d;
    logic        int_q, int_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [5:0] addr;
    logic       access, busy, full;
    logic       go, go_init;
    logic       unused_ok;

    assign paddr     = apb.PADDR;
    assign addr      = paddr[7:2];
    assign unused_ok = ^paddr;
    // pready_q masks the completion edge so a held access is not taken twice
    assign access    = apb.PSEL & apb.PENABLE & ~pready_q;
    assign busy      = (state_q == HASH);
    assign full      = (cnt_q == FULL_CNT);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        dig_d       = dig_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        int_flag_d  = int_flag_q;
        err_d       = err_q;
        auto_pend_d = 1'b0;
        start_d     = 1'b0;
        init_d      = init_q;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        go          = 1'b0;
        go_init     = 1'b0;

        if (access) begin
            pready_d = 1'b1;
            if (apb.PWRITE) begin
                case (addr)
                    A_CTRL: ctrl_d = apb.PWDATA[2:0];
                    A_CMD: begin
                        // flush, clr_int, start evaluated in that order; start sees the flushed count
                        if (apb.PWDATA[3]) begin
                            if (busy) pslverr_d = 1'b1;
                            else      cnt_d = '0;
                        end
                        if (apb.PWDATA[0]) begin
                            int_flag_d = 1'b0;
                            err_d      = 1'b0;
                        end
                        if (apb.PWDATA[1]) begin
                            if (busy || cnt_d != FULL_CNT) begin
                                pslverr_d = 1'b1;
                            end else begin
                                go      = 1'b1;
                                go_init = apb.PWDATA[2];
                            end
                        end
                    end
                    A_MSG: begin
                        if (busy || full) begin
                            pslverr_d = 1'b1;
                        end else begin
                            for (int i = 0; i < MSG_WORDS; i++) begin
                                if (int'(cnt_q) == i) buf_d[i] = apb.PWDATA;
                            end
                            cnt_d       = cnt_q + 5'd1;
                            auto_pend_d = ctrl_q[1] && ((cnt_q + 5'd1) == FULL_CNT);
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (addr)
                    A_CTRL:   prdata_d = {29'd0, ctrl_q};
                    A_STATUS: prdata_d = {19'd0, cnt_q, 4'd0, err_q, full, busy, int_flag_q};
                    default: begin
                        for (int i = 0; i < DIGEST_WORDS; i++) begin
                            if (int'(addr) == A_DIG + i) prdata_d = dig_q[i];
                        end
                    end
                endcase
            end
            if (pslverr_d) err_d = 1'b1;
        end

        if (auto_pend_q && !busy && full) begin
            go      = 1'b1;
            go_init = ctrl_q[2];
        end

        // done is applied last so it overrides a same-cycle clr_int
        case (state_q)
            IDLE: begin
                if (go) begin
                    start_d = 1'b1;
                    init_d  = go_init;
                    state_d = HASH;
                end
            end
            HASH: begin
                if (core_done_i) begin
                    for (int i = 0; i < DIGEST_WORDS; i++) begin
                        dig_d[i] = core_digest_i[32*(DIGEST_WORDS-1-i) +: 32];
                    end
                    cnt_d      = '0;
                    int_flag_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        int_d = ctrl_q[0] & int_flag_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            for (int i = 0; i < MSG_WORDS; i++)    buf_q[i] <= '0;
            for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            int_flag_q  <= 1'b0;
            err_q       <= 1'b0;
            auto_pend_q <= 1'b0;
            start_q     <= 1'b0;
            init_q      <= 1'b0;
            int_q       <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            dig_q       <= dig_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            int_flag_q  <= int_flag_d;
            err_q       <= err_d;
            auto_pend_q <= auto_pend_d;
            start_q     <= start_d;
            init_q      <= init_d;
            int_q       <= int_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
        end
    end

    for (genvar g = 0; g < MSG_WORDS; g++) begin : g_block
        assign core_block_o[32*(MSG_WORDS-1-g) +: 32] = buf_q[g];
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign core_start_o = start_q;
    assign core_init_o  = init_q;
    assign int_o        = int_q;
endmodule
